mac_array_ctrl: RTL

- Sequences one weight-stationary pass of the ROW x COL mac_tile array: weight fill, kernel load, settle, activation stream, psum drain.
- Drives the shared SRAM read port and the west-edge L0 FIFO, and issues inst_w[1:0] (bit1 execute, bit0 kernel load) into column 0. Tiles propagate inst eastward themselves.
- Counts psum vectors leaving the OFIFO and signals completion.

---
 rtl/mac_ctrl_pkg.sv | 18 +
 rtl/mac_ctrl_issue_pipe.sv | 31 +++
 rtl/mac_array_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared state encoding and instruction codes for the MAC array controller
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_FILL,
    W_LOAD,
    W_SETTLE,
    X_STREAM,
    DRAIN,
    DONE
  } state_e;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_ctrl_issue_pipe.sv
// rtl/mac_ctrl_issue_pipe.sv - two-stage delay from SRAM read to L0 write and L0 pop/execute
module mac_ctrl_issue_pipe (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic exec_i,
  output logic wr_o,
  output logic exec_rd_o
);

  logic s1_q;
  logic s1_exec_q;
  logic s2_q;

  // Weight reads travel stage 1 only; activation reads continue to the pop stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s1_exec_q <= 1'b0;
      s2_q      <= 1'b0;
    end else begin
      s1_q      <= push_i;
      s1_exec_q <= push_i & exec_i;
      s2_q      <= s1_exec_q;
    end
  end

  assign wr_o      = s1_q;
  assign exec_rd_o = s2_q;

endmodule

// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - weight-stationary pass sequencer; optional perf counters under MAC_ARRAY_CTRL_PERF_EN
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int ROW = 8,
  parameter int COL = 8,
  parameter int AW  = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] x_base,
  input  logic [AW-1:0] num_vec,
  output logic          sram_rd,
  output logic [AW-1:0] sram_addr,
  output logic          l0_wr,
  output logic          l0_rd,
  input  logic          l0_full,
  output logic [1:0]    inst_w,
  input  logic          ofifo_valid,
  output logic          ofifo_rd,
  output logic          busy,
  output logic          done
`ifdef MAC_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_stall
`endif
);

  localparam logic [AW-1:0] COL_C       = AW'(COL);
  localparam logic [AW-1:0] SETTLE_LAST = AW'(ROW + COL - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] w_base_q, w_base_d;
  logic [AW-1:0] x_base_q, x_base_d;
  logic [AW-1:0] num_vec_q, num_vec_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] ld_cnt_q, ld_cnt_d;
  logic [AW-1:0] iss_cnt_q, iss_cnt_d;
  logic [AW-1:0] out_cnt_q, out_cnt_d;
  logic          exec_rd;

  mac_ctrl_issue_pipe u_issue_pipe (
    .clk       (clk),
    .reset     (reset),
    .push_i    (sram_rd),
    .exec_i    (state_q == X_STREAM),
    .wr_o      (l0_wr),
    .exec_rd_o (exec_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      w_base_q  <= '0;
      x_base_q  <= '0;
      num_vec_q <= '0;
      rd_cnt_q  <= '0;
      ld_cnt_q  <= '0;
      iss_cnt_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      w_base_q  <= w_base_d;
      x_base_q  <= x_base_d;
      num_vec_q <= num_vec_d;
      rd_cnt_q  <= rd_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      iss_cnt_q <= iss_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    w_base_d  = w_base_q;
    x_base_d  = x_base_q;
    num_vec_d = num_vec_q;
    rd_cnt_d  = rd_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    iss_cnt_d = iss_cnt_q;
    sram_rd   = 1'b0;
    sram_addr = '0;
    l0_rd     = 1'b0;
    inst_w    = INST_IDLE;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    ofifo_rd  = ofifo_valid && ((state_q == X_STREAM) || (state_q == DRAIN));
    out_cnt_d = out_cnt_q + {{(AW-1){1'b0}}, ofifo_rd};

    case (state_q)
      IDLE: begin
        if (start) begin
          w_base_d  = w_base;
          x_base_d  = x_base;
          num_vec_d = num_vec;
          rd_cnt_d  = '0;
          ld_cnt_d  = '0;
          iss_cnt_d = '0;
          out_cnt_d = '0;
          state_d   = (num_vec != '0) ? W_FILL : DONE;
        end
      end
      W_FILL: begin
        // The extra cycle at rd_cnt == COL lets the last L0 write land.
        if (rd_cnt_q == COL_C) begin
          rd_cnt_d = '0;
          state_d  = W_LOAD;
        end else begin
          sram_rd   = 1'b1;
          sram_addr = w_base_q + rd_cnt_q;
          rd_cnt_d  = rd_cnt_q + 1'b1;
        end
      end
      W_LOAD: begin
        l0_rd  = 1'b1;
        inst_w = INST_LOAD;
        if (ld_cnt_q == COL_C - 1'b1) begin
          ld_cnt_d = '0;
          state_d  = W_SETTLE;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      W_SETTLE: begin
        if (ld_cnt_q == SETTLE_LAST) begin
          ld_cnt_d = '0;
          state_d  = X_STREAM;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      X_STREAM: begin
        sram_addr = x_base_q + rd_cnt_q;
        if ((rd_cnt_q < num_vec_q) && !l0_full) begin
          sram_rd  = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (exec_rd) begin
          l0_rd     = 1'b1;
          inst_w    = INST_EXEC;
          iss_cnt_d = iss_cnt_q + 1'b1;
          if (iss_cnt_q == num_vec_q - 1'b1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Includes this cycle's pop so done follows the final read directly.
        if (out_cnt_d == num_vec_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if ((state_q == IDLE) && start) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy) perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == X_STREAM) && l0_full) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
